// File: rtl/elastic_mux_arbiter_pkg.sv
// Shared parameters, encodings and config record for the elastic mux arbiter.
package elastic_mux_arbiter_pkg;
    localparam int NEIGHBOR_PE_NUM            = 5;
    localparam int NEIGHBOR_PE_NUM_BIT_LENGTH = 3;
    localparam int BURST_WIDTH                = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    typedef struct packed {
        logic                                  mode;
        logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] index;
        logic [BURST_WIDTH-1:0]                burst;
    } cfg_t;

    function automatic logic [NEIGHBOR_PE_NUM-1:0] idx_onehot(
        input logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] i);
        idx_onehot    = '0;
        idx_onehot[i] = 1'b1;
    endfunction
endpackage

// File: rtl/elastic_mux_arbiter_if.sv
// Handshake, select and config bundle between the arbiter and its mux/neighbours.
interface elastic_mux_arbiter_if;
    import elastic_mux_arbiter_pkg::*;

    logic [NEIGHBOR_PE_NUM-1:0]            valid_input;
    logic [NEIGHBOR_PE_NUM-1:0]            stop_input;
    logic                                  stop_output;
    logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] input_data_index;
    logic                                  grant_valid;
    logic                                  valid_output;
    logic                                  cfg_we;
    logic                                  cfg_mode;
    logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] cfg_index;
    logic [BURST_WIDTH-1:0]                cfg_burst;
    logic                                  cfg_error;

    modport master (
        input  valid_input, stop_output, cfg_we, cfg_mode, cfg_index, cfg_burst,
        output stop_input, input_data_index, grant_valid, valid_output, cfg_error
    );

    modport slave (
        output valid_input, stop_output, cfg_we, cfg_mode, cfg_index, cfg_burst,
        input  stop_input, input_data_index, grant_valid, valid_output, cfg_error
    );
endinterface

// File: rtl/elastic_mux_arbiter_picker.sv
// Cyclic priority search: first requesting, non-excluded input after ptr.
module round_robin_picker
    import elastic_mux_arbiter_pkg::*;
(
    input  logic [NEIGHBOR_PE_NUM-1:0]            req,
    input  logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] ptr,
    input  logic [NEIGHBOR_PE_NUM-1:0]            excl,
    output logic [NEIGHBOR_PE_NUM_BIT_LENGTH-1:0] pick,
    output logic                                  found
);
    int c;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        c     = 0;
        // ptr itself is visited last, so it only wins when it is the sole candidate
        for (int i = 1; i <= NEIGHBOR_PE_NUM; i++) begin
            c = (int'(ptr) + i) % NEIGHBOR_PE_NUM;
            if (!found && req[c] && !excl[c]) begin
                found = 1'b1;
                pick  = NEIGHBOR_PE_NUM_BIT_LENGTH'(c);
            end
        end
    end
endmodule

// File: rtl/elastic_mux_arbiter.sv
// Select/stop sequencer for one elastic multiplexer: static route or round-robin bursts.
module elastic_mux_arbiter
    import elastic_mux_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    elastic_mux_arbiter_if.master bus
);
    localparam int IW = NEIGHBOR_PE_NUM_BIT_LENGTH;

    cfg_t                   cfg_q;
    logic                   cfg_error_q;
    arb_state_e             state_q, state_d;
    logic [IW-1:0]          sel_q, sel_d, last_q, last_d;
    logic [BURST_WIDTH-1:0] beats_q, beats_d;
    logic                   gv_q, gv_d;
    logic                   cfg_ok, cfg_bad, xfer;
    logic [IW-1:0]          pick;
    logic                   pick_found;
    logic [NEIGHBOR_PE_NUM-1:0] excl;

    assign cfg_ok  = bus.cfg_we && (int'(bus.cfg_index) < NEIGHBOR_PE_NUM);
    assign cfg_bad = bus.cfg_we && !(int'(bus.cfg_index) < NEIGHBOR_PE_NUM);
    assign xfer    = gv_q && bus.valid_input[sel_q] && !bus.stop_output;
    // The end-of-burst re-pick must hand over to someone else if anyone else is waiting
    assign excl    = (state_q == ARB_GRANT) ? idx_onehot(sel_q) : '0;

    round_robin_picker u_picker (
        .req   (bus.valid_input),
        .ptr   (last_q),
        .excl  (excl),
        .pick  (pick),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q       <= '0;
            cfg_error_q <= 1'b0;
            state_q     <= ARB_IDLE;
            sel_q       <= '0;
            last_q      <= IW'(NEIGHBOR_PE_NUM - 1);
            beats_q     <= '0;
            gv_q        <= 1'b0;
        end else begin
            if (cfg_ok)  cfg_q       <= '{mode: bus.cfg_mode, index: bus.cfg_index, burst: bus.cfg_burst};
            if (cfg_bad) cfg_error_q <= 1'b1;
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            beats_q <= beats_d;
            gv_q    <= gv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        beats_d = beats_q;
        gv_d    = gv_q;
        if (cfg_ok) begin
            // New config takes the route straight away; RR restarts from IDLE
            state_d = ARB_IDLE;
            beats_d = '0;
            sel_d   = bus.cfg_index;
            gv_d    = (bus.cfg_mode == MODE_STATIC);
        end else if (cfg_q.mode == MODE_STATIC) begin
            state_d = ARB_IDLE;
            beats_d = '0;
            sel_d   = cfg_q.index;
            gv_d    = 1'b1;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    gv_d = 1'b0;
                    if (pick_found) begin
                        state_d = ARB_GRANT;
                        sel_d   = pick;
                        last_d  = pick;
                        beats_d = cfg_q.burst;
                        gv_d    = 1'b1;
                    end
                end
                ARB_GRANT: begin
                    if (!bus.valid_input[sel_q]) begin
                        state_d = ARB_IDLE;
                        gv_d    = 1'b0;
                    end else if (xfer) begin
                        if (beats_q != '0) begin
                            beats_d = beats_q - BURST_WIDTH'(1);
                        end else if (pick_found) begin
                            sel_d   = pick;
                            last_d  = pick;
                            beats_d = cfg_q.burst;
                        end else begin
                            state_d = ARB_IDLE;
                            gv_d    = 1'b0;
                        end
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.stop_input = '1;
        if (gv_q) bus.stop_input[sel_q] = bus.stop_output;
    end

    assign bus.input_data_index = sel_q;
    assign bus.grant_valid      = gv_q;
    assign bus.valid_output     = gv_q && bus.valid_input[sel_q];
    assign bus.cfg_error        = cfg_error_q;
endmodule

// File: tb/tb_elastic_mux_arbiter.sv
// Scenario bench for elastic_mux_arbiter with a transfer scoreboard.
module tb_elastic_mux_arbiter;
    import elastic_mux_arbiter_pkg::*;

    logic clk;
    logic reset_n;
    int   vec;
    int   errs;
    int   exp_q[$];

    elastic_mux_arbiter_if bus ();

    elastic_mux_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic mode, input logic [2:0] index, input logic [3:0] burst);
        bus.cfg_mode  = mode;
        bus.cfg_index = index;
        bus.cfg_burst = burst;
        bus.cfg_we    = 1'b1;
        cyc();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic test_reset;
        reset_n         = 1'b0;
        bus.valid_input = 5'b00000;
        bus.stop_output = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_mode    = 1'b0;
        bus.cfg_index   = '0;
        bus.cfg_burst   = '0;
        #1;
        vec++; if (bus.grant_valid !== 1'b0) begin errs++; $display("FAIL rst_gv got %b want 0", bus.grant_valid); end
        vec++; if (bus.stop_input !== 5'b11111) begin errs++; $display("FAIL rst_stop got %b want 11111", bus.stop_input); end
        vec++; if (bus.input_data_index !== 3'd0 || bus.cfg_error !== 1'b0 || bus.valid_output !== 1'b0) begin
            errs++; $display("FAIL rst_regs got idx=%0d err=%b vo=%b want 0/0/0", bus.input_data_index, bus.cfg_error, bus.valid_output); end
        cyc(2);
        reset_n = 1'b1;
        cyc();
        vec++; if (bus.grant_valid !== 1'b1 || bus.input_data_index !== 3'd0) begin
            errs++; $display("FAIL rst_static_up got gv=%b idx=%0d want 1/0", bus.grant_valid, bus.input_data_index); end
    endtask

    task automatic test_static;
        cfg_write(MODE_STATIC, 3'd2, 4'd0);
        vec++; if (bus.input_data_index !== 3'd2 || bus.grant_valid !== 1'b1) begin
            errs++; $display("FAIL static_route got idx=%0d gv=%b want 2/1", bus.input_data_index, bus.grant_valid); end
        bus.stop_output = 1'b1; #1;
        vec++; if (bus.stop_input !== 5'b11111) begin errs++; $display("FAIL static_stop1 got %b want 11111", bus.stop_input); end
        bus.stop_output = 1'b0; #1;
        vec++; if (bus.stop_input !== 5'b11011) begin errs++; $display("FAIL static_stop0 got %b want 11011", bus.stop_input); end
        bus.valid_input = 5'b00100; #1;
        vec++; if (bus.valid_output !== 1'b1) begin errs++; $display("FAIL static_vo1 got %b want 1", bus.valid_output); end
        bus.valid_input = 5'b00010; #1;
        vec++; if (bus.valid_output !== 1'b0) begin errs++; $display("FAIL static_vo0 got %b want 0", bus.valid_output); end
        bus.valid_input = 5'b00000;
    endtask

    task automatic test_cfg_error;
        cfg_write(MODE_RR, 3'd5, 4'd3);
        vec++; if (bus.cfg_error !== 1'b1) begin errs++; $display("FAIL cfg_err_set got %b want 1", bus.cfg_error); end
        cyc(3);
        vec++; if (bus.input_data_index !== 3'd2 || bus.grant_valid !== 1'b1) begin
            errs++; $display("FAIL cfg_err_dropped got idx=%0d gv=%b want 2/1", bus.input_data_index, bus.grant_valid); end
        cfg_write(MODE_STATIC, 3'd1, 4'd0);
        vec++; if (bus.cfg_error !== 1'b1 || bus.input_data_index !== 3'd1) begin
            errs++; $display("FAIL cfg_err_sticky got err=%b idx=%0d want 1/1", bus.cfg_error, bus.input_data_index); end
    endtask

    task automatic test_rotation;
        int n;
        int e;
        bus.valid_input = 5'b01011;
        bus.stop_output = 1'b0;
        cfg_write(MODE_RR, 3'd0, 4'd1);
        vec++; if (bus.grant_valid !== 1'b0) begin errs++; $display("FAIL rr_idle got gv=%b want 0", bus.grant_valid); end
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q = {0, 0, 1, 1, 3, 3, 0, 0, 1, 1};
        cyc();
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            if (bus.valid_output && !bus.stop_output) begin
                e = exp_q.pop_front();
                vec++;
                if (int'(bus.input_data_index) !== e) begin
                    errs++; $display("FAIL rr_grant beat %0d got idx=%0d want %0d", n, bus.input_data_index, e);
                end
            end
            n++;
            cyc();
        end
        vec++; if (n !== 10 || exp_q.size() !== 0) begin
            errs++; $display("FAIL rr_no_bubble got %0d cycles, %0d left want 10 cycles, 0 left", n, exp_q.size()); end
        bus.valid_input = 5'b00000;
        cyc(2);
    endtask

    task automatic test_stall;
        int e;
        bus.stop_output = 1'b1;
        bus.valid_input = 5'b00010;
        cfg_write(MODE_RR, 3'd0, 4'd0);
        cyc();
        vec++; if (bus.grant_valid !== 1'b1 || bus.input_data_index !== 3'd1) begin
            errs++; $display("FAIL stall_grant got gv=%b idx=%0d want 1/1", bus.grant_valid, bus.input_data_index); end
        bus.valid_input = 5'b00110;
        for (int k = 0; k < 5; k++) begin
            #1;
            vec++; if (bus.input_data_index !== 3'd1 || bus.valid_output !== 1'b1 || bus.stop_input !== 5'b11111) begin
                errs++; $display("FAIL stall_hold cyc %0d got idx=%0d vo=%b stop=%b want 1/1/11111", k, bus.input_data_index, bus.valid_output, bus.stop_input); end
            cyc();
        end
        exp_q.push_back(1);
        exp_q.push_back(2);
        bus.stop_output = 1'b0; #1;
        vec++; if (bus.stop_input !== 5'b11101) begin errs++; $display("FAIL stall_release_stop got %b want 11101", bus.stop_input); end
        for (int k = 0; k < 2; k++) begin
            if (bus.valid_output && !bus.stop_output && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vec++; if (int'(bus.input_data_index) !== e) begin
                    errs++; $display("FAIL stall_xfer %0d got idx=%0d want %0d", k, bus.input_data_index, e); end
            end
            if (k == 1) bus.valid_input = 5'b00000;
            cyc();
        end
        vec++; if (exp_q.size() !== 0) begin errs++; $display("FAIL stall_xfer_count got %0d left want 0", exp_q.size()); end
        foreach (exp_q[i]) exp_q.delete(i);
        cyc();
        vec++; if (bus.grant_valid !== 1'b0) begin errs++; $display("FAIL stall_idle got gv=%b want 0", bus.grant_valid); end
    endtask

    task automatic test_valid_drop;
        bus.stop_output = 1'b0;
        bus.valid_input = 5'b01000;
        cfg_write(MODE_RR, 3'd0, 4'd3);
        cyc();
        vec++; if (bus.grant_valid !== 1'b1 || bus.input_data_index !== 3'd3) begin
            errs++; $display("FAIL drop_grant got gv=%b idx=%0d want 1/3", bus.grant_valid, bus.input_data_index); end
        cyc();
        bus.valid_input = 5'b10001; #1;
        vec++; if (bus.valid_output !== 1'b0 || bus.stop_input !== 5'b10111) begin
            errs++; $display("FAIL drop_comb got vo=%b stop=%b want 0/10111", bus.valid_output, bus.stop_input); end
        cyc();
        vec++; if (bus.grant_valid !== 1'b0 || bus.stop_input !== 5'b11111) begin
            errs++; $display("FAIL drop_bubble got gv=%b stop=%b want 0/11111", bus.grant_valid, bus.stop_input); end
        cyc();
        vec++; if (bus.grant_valid !== 1'b1 || bus.input_data_index !== 3'd4) begin
            errs++; $display("FAIL drop_rearb got gv=%b idx=%0d want 1/4", bus.grant_valid, bus.input_data_index); end
        bus.valid_input = 5'b00000;
        cyc(2);
    endtask

    task automatic test_reset_mid_burst;
        bus.stop_output = 1'b0;
        bus.valid_input = 5'b00100;
        cfg_write(MODE_RR, 3'd0, 4'd7);
        cyc(2);
        vec++; if (bus.grant_valid !== 1'b1 || bus.input_data_index !== 3'd2) begin
            errs++; $display("FAIL mid_grant got gv=%b idx=%0d want 1/2", bus.grant_valid, bus.input_data_index); end
        reset_n = 1'b0; #1;
        vec++; if (bus.grant_valid !== 1'b0 || bus.stop_input !== 5'b11111 || bus.valid_output !== 1'b0) begin
            errs++; $display("FAIL mid_reset got gv=%b stop=%b vo=%b want 0/11111/0", bus.grant_valid, bus.stop_input, bus.valid_output); end
        vec++; if (bus.cfg_error !== 1'b0) begin errs++; $display("FAIL mid_reset_err got %b want 0", bus.cfg_error); end
        cyc(2);
        bus.valid_input = 5'b01010;
        reset_n = 1'b1;
        cyc();
        cfg_write(MODE_RR, 3'd0, 4'd0);
        cyc();
        vec++; if (bus.grant_valid !== 1'b1 || bus.input_data_index !== 3'd1) begin
            errs++; $display("FAIL mid_first_grant got gv=%b idx=%0d want 1/1", bus.grant_valid, bus.input_data_index); end
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        test_reset();
        test_static();
        test_cfg_error();
        test_rotation();
        test_stall();
        test_valid_drop();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/elastic_mux_arbiter.md
# elastic_mux_arbiter

Sequencer and arbiter for one PE-input elastic multiplexer. It drives the multiplexer's `input_data_index`, generates per-input `stop_input` back-pressure, and gates the multiplexer's `valid_output`. It runs in one of two modes:
- **Static:** a fixed, configured route, which is the normal CGRA mapping.
- **Round-robin:** bursts are shared between requesting neighbour PEs.

It sits beside each `ElasticMultiplexer` instance. It owns the multiplexer's select and stop signals, so the multiplexer's broadcast `stop_input` is left unconnected.

## Interface
Parameters (from `param.v`, global):
- `NEIGHBOR_PE_NUM`, from `param.v`: number of mux inputs.
- `NEIGHBOR_PE_NUM_BIT_LENGTH`, from `param.v`: select width.
- `BURST_WIDTH`, default 4: width of the burst-length field; burst = `cfg_burst`+1 beats.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `valid_input[NEIGHBOR_PE_NUM]`  in  1 each  upstream valids.
- `stop_input[NEIGHBOR_PE_NUM]`  out  1 each  per-input stop.
- `stop_output`  in  1  downstream stop.
- `input_data_index`  out  `NEIGHBOR_PE_NUM_BIT_LENGTH`  select, registered.
- `grant_valid`  out  1  select is live.
- `valid_output`  out  1  `grant_valid & valid_input[input_data_index]`.
- `cfg_we`  in  1  config write strobe.
- `cfg_mode`  in  1  0 = static, 1 = round-robin.
- `cfg_index`  in  `NEIGHBOR_PE_NUM_BIT_LENGTH`  static route.
- `cfg_burst`  in  `BURST_WIDTH`  beats per grant minus 1.
- `cfg_error`  out  1  sticky; set by an out-of-range `cfg_index` write.

## Operation
- **Config registers:** `mode`, `index`, `burst`.
  - Reset values: 0, 0, 0.
  - A `cfg_we` write loads all three together, effective the next cycle. It also forces the FSM to IDLE and clears the beat counter.
  - A write with `cfg_index` ≥ `NEIGHBOR_PE_NUM` is dropped entirely and sets `cfg_error`. `cfg_error` clears only on reset.
- **Stop:**
  - Granted input: `stop_input[idx] = stop_output`.
  - Every other input, and all inputs when `grant_valid`=0: `stop_input` = 1.
  - `stop_input` is combinational.
- **Transfer:** a beat transfers when `valid_input[idx] & grant_valid & !stop_output`.
- **Static mode:**
  - `input_data_index` = `index`, `grant_valid` = 1.
  - The FSM and beat counter are held at IDLE / 0.
- **Round-robin mode, FSM states IDLE and GRANT:**
  - Picker: a cyclic search over `valid_input` starting at `last+1`, with an optional exclude mask.
  - IDLE → GRANT when any input is valid. Pick with no exclusion. Load `input_data_index` and `last` with the pick, set `grant_valid`=1, and set beats = `burst`.
  - GRANT, transfer, beats > 0: decrement beats and stay.
  - GRANT, transfer, beats = 0 (last beat): re-pick, excluding `idx`.
    - If another input is valid: go straight to GRANT on it, with no bubble.
    - Otherwise: go to IDLE with `grant_valid`=0.
  - GRANT, `valid_input[idx]`=0: release to IDLE, with `grant_valid`=0 the next cycle.
  - GRANT, stalled (valid & stop): hold everything.
- **Simultaneous events:** `cfg_we` has priority over FSM transitions.
- **Reset mid-burst:** the burst is abandoned and all state returns to its reset value immediately.

## Timing
- Reset values:
  - `input_data_index`=0, `grant_valid`=0, `cfg_error`=0.
  - `stop_input` all 1, `valid_output`=0.
  - FSM IDLE, beats 0, `last`=`NEIGHBOR_PE_NUM`-1, so the first pick searches from input 0.
- Static mode: `grant_valid` rises on the first `clk` edge after `reset_n` deasserts.
- Round-robin latency:
  - One cycle from a request seen in IDLE to `grant_valid`.
  - Zero bubbles between back-to-back grants.
  - One bubble when the granting input's valid drops.
- A burst of N beats with no stalls occupies exactly N cycles.
- The beat counter never wraps: it decrements only from a nonzero value.

## Structure
- Add to `param.v`:
  - `BURST_WIDTH`.
  - The arbiter state encoding (`ARB_IDLE`=0, `ARB_GRANT`=1).
  - The mode encoding (`MODE_STATIC`=0, `MODE_RR`=1).
- One sub-module, `RoundRobinPicker`: a combinational cyclic priority search.
  - Inputs: request vector, start pointer, exclude mask.
  - Outputs: index and found flag.
- Top-level wrapper glue (not part of this block): the multiplexer's `valid_output` is ANDed with `grant_valid`, or `valid_output` from this block is used directly.

## Test plan
- **Static route after reset:** reset, then write mode=0, index=2. Expect `input_data_index`=2 and `grant_valid`=1 next cycle, `stop_input[2]` following `stop_output`, and all other `stop_input`=1.
- **Out-of-range config:** write `cfg_index`=`NEIGHBOR_PE_NUM`. Expect `cfg_error`=1, config unchanged; it stays 1 until reset.
- **Round-robin rotation:** mode=1, burst=1 (2 beats), inputs 0, 1, 3 valid continuously, `stop_output`=0. Expect grants 0, 0, 1, 1, 3, 3, 0… with no idle cycles.
- **Stall hold:** grant on input 1 with burst=0, hold `stop_output`=1 for 5 cycles. Expect index held, `valid_output`=1 throughout, a transfer on release, then a re-pick.
- **Valid drop:** granted input deasserts valid mid-burst. Expect `grant_valid`=0 next cycle, then re-arbitration from `last+1`.
- **Reset mid-burst:** assert `reset_n`=0 mid-burst. Expect `grant_valid`=0 and all `stop_input`=1 immediately. After release, the first grant goes to the lowest valid input.
